sh_seq_ctrl: RTL and testbench

- Sequencer that drives a 16-bit load/shift register (sh_rgst) as a full-duplex serial shift engine, SPI-style.
- Accepts a parallel word and a bit count on a start strobe, then loads the register.
- Shifts MSB-first for the requested number of cycles while capturing serial input into the LSB.
- Returns the received bits in parallel with a one-cycle done pulse.

---
 rtl/sh_pkg.sv | 21 ++
 rtl/sh_rgst.sv | 24 ++
 rtl/sh_seq_ctrl.sv | 99 +++++++++
 tb/tb_sh_seq_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sh_pkg.sv
// Shared constants, state encoding and length normalisation for the shift sequencer.
package sh_pkg;

  localparam int unsigned W     = 16;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } sh_state_e;

  // Zero or anything wider than the register means a full-width transfer.
  function automatic logic [CNT_W-1:0] norm_len(input logic [CNT_W-1:0] l);
    if (l == '0 || 32'(l) > W) begin
      return CNT_W'(W);
    end
    return l;
  endfunction

endpackage

// File: rtl/sh_rgst.sv
// Load/shift register: parallel load has priority over a left shift with serial fill.
module sh_rgst #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         ld,
  input  logic         sh,
  input  logic         sh_in,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (sh) begin
      q <= {q[W-2:0], sh_in};
    end
  end

endmodule

// File: rtl/sh_seq_ctrl.sv
// Full-duplex serial shift sequencer: loads a word, shifts it out MSB-first, captures rx bits.
module sh_seq_ctrl #(
  parameter int unsigned W     = sh_pkg::W,
  parameter int unsigned CNT_W = sh_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [W-1:0]     tx_data,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     rx_data
);

  import sh_pkg::*;

  sh_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] len_q;
  logic [W-1:0]     rx_data_q;
  logic [W-1:0]     q;
  logic [W-1:0]     q_next;
  logic [W-1:0]     len_mask;
  logic             ld;
  logic             sh;

  assign ld = (state_q == StIdle) && start;
  assign sh = (state_q == StShift);

  sh_rgst #(
    .W (W)
  ) u_sh_rgst (
    .clk   (clk),
    .rst_b (rst_b),
    .ld    (ld),
    .sh    (sh),
    .sh_in (ser_in),
    .d     (tx_data),
    .q     (q)
  );

  // Register contents after the final shift edge, as seen by the capture.
  assign q_next = {q[W-2:0], ser_in};

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < int'(W); i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      len_q     <= '0;
      rx_data_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StShift;
            len_q   <= norm_len(len);
            cnt_q   <= norm_len(len);
          end
        end
        StShift: begin
          if (abort) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q   <= StDone;
              rx_data_q <= q_next & len_mask;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ser_out  = q[W-1];
  assign shift_en = (state_q == StShift);
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_sh_seq_ctrl.sv
// Directed bench for sh_seq_ctrl with hand-computed expectations.
module tb_sh_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        start;
  logic [15:0] tx_data;
  logic [4:0]  len;
  logic        abort;
  logic        ser_drv;
  logic        loop_en;
  logic        ser_in;
  logic        ser_out;
  logic        shift_en;
  logic        busy;
  logic        done;
  logic [15:0] rx_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] seq;
  int          shifts;
  int          dones;
  int          busy_cyc;

  assign ser_in = loop_en ? ser_out : ser_drv;

  always #5 clk = ~clk;

  sh_seq_ctrl dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .start    (start),
    .tx_data  (tx_data),
    .len      (len),
    .abort    (abort),
    .ser_in   (ser_in),
    .ser_out  (ser_out),
    .shift_en (shift_en),
    .busy     (busy),
    .done     (done),
    .rx_data  (rx_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts a transfer and watches it to completion; poke_at injects a start or abort
  // during that SHIFT cycle. A few idle cycles afterwards catch any stray done pulse.
  task automatic run_xfer(input logic [15:0] tx, input logic [4:0] l, input logic ser,
                          input logic lp, input int poke_at, input logic poke_abort);
    tx_data  = tx;
    len      = l;
    ser_drv  = ser;
    loop_en  = lp;
    seq      = '0;
    shifts   = 0;
    dones    = 0;
    busy_cyc = 0;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!busy) break;
      busy_cyc++;
      if (done) dones++;
      if (shift_en) begin
        seq = {seq[30:0], ser_out};
        shifts++;
        if (shifts == poke_at) begin
          if (poke_abort) begin
            abort = 1'b1;
          end else begin
            start   = 1'b1;
            tx_data = 16'hFFFF;
          end
        end
      end
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    loop_en = 1'b0;
  endtask

  initial begin
    rst_b   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    tx_data = '0;
    len     = '0;
    ser_drv = 1'b0;
    loop_en = 1'b0;
    #12;
    check_eq("rst_outputs", {12'd0, ser_out, shift_en, busy, done, rx_data}, 32'h0);
    rst_b = 1'b1;
    @(posedge clk); #1;

    // Basic 8-bit transfer, ser_in held high.
    run_xfer(16'hAB00, 5'd8, 1'b1, 1'b0, 0, 1'b0);
    check_eq("t1_seq", seq, 32'h0000_00AB);
    check_eq("t1_shifts", 32'(shifts), 32'd8);
    check_eq("t1_dones", 32'(dones), 32'd1);
    check_eq("t1_busy", 32'(busy_cyc), 32'd9);
    check_eq("t1_rx", {16'h0, rx_data}, 32'h0000_00FF);

    // len=0 means 16, loopback returns the transmitted word.
    run_xfer(16'h1234, 5'd0, 1'b0, 1'b1, 0, 1'b0);
    check_eq("t2_seq", seq, 32'h0000_1234);
    check_eq("t2_shifts", 32'(shifts), 32'd16);
    check_eq("t2_dones", 32'(dones), 32'd1);
    check_eq("t2_rx", {16'h0, rx_data}, 32'h0000_1234);

    // Start while busy is ignored.
    run_xfer(16'hC300, 5'd8, 1'b1, 1'b0, 3, 1'b0);
    check_eq("t3_seq", seq, 32'h0000_00C3);
    check_eq("t3_shifts", 32'(shifts), 32'd8);
    check_eq("t3_dones", 32'(dones), 32'd1);
    check_eq("t3_rx", {16'h0, rx_data}, 32'h0000_00FF);

    // Abort in the 3rd SHIFT cycle: no done, rx unchanged.
    run_xfer(16'h5500, 5'd8, 1'b0, 1'b0, 3, 1'b1);
    check_eq("t4_shifts", 32'(shifts), 32'd3);
    check_eq("t4_busy", 32'(busy_cyc), 32'd3);
    check_eq("t4_dones", 32'(dones), 32'd0);
    check_eq("t4_rx", {16'h0, rx_data}, 32'h0000_00FF);

    // Asynchronous reset mid-SHIFT.
    tx_data = 16'hAB00;
    len     = 5'd8;
    ser_drv = 1'b1;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check_eq("t5_pre_busy", {31'd0, busy}, 32'd1);
    #1;
    rst_b = 1'b0;
    #1;
    check_eq("t5_rst_outs", {12'd0, ser_out, shift_en, busy, done, rx_data}, 32'h0);
    #24;
    rst_b = 1'b1;
    @(posedge clk); #1;
    run_xfer(16'h0000, 5'd1, 1'b1, 1'b0, 0, 1'b0);
    check_eq("t5_shifts", 32'(shifts), 32'd1);
    check_eq("t5_dones", 32'(dones), 32'd1);
    check_eq("t5_busy", 32'(busy_cyc), 32'd2);
    check_eq("t5_rx", {16'h0, rx_data}, 32'h0000_0001);

    // len above 16 saturates.
    run_xfer(16'h8001, 5'd20, 1'b0, 1'b0, 0, 1'b0);
    check_eq("t6_shifts", 32'(shifts), 32'd16);
    check_eq("t6_seq", seq, 32'h0000_8001);
    check_eq("t6_dones", 32'(dones), 32'd1);
    check_eq("t6_rx", {16'h0, rx_data}, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
